// File: rtl/linear_weight_loader_pkg.sv
// Shared definitions for the linear-weight SRAM loader and its reader side:
// FSM state encoding, default geometry and the byte-lane positions inside a word.
package linear_weight_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD_HI = 3'd1,
        ST_LOAD_LO = 3'd2,
        ST_WRITE   = 3'd3,
        ST_DONE    = 3'd4
    } lw_state_t;

    localparam int LW_NUM_WORDS = 64;
    localparam int LW_ADDR_W    = 9;

    // weight0 sits in the upper lane, weight1 in the lower lane
    localparam int LANE_HI_MSB = 15;
    localparam int LANE_HI_LSB = 8;
    localparam int LANE_LO_MSB = 7;
    localparam int LANE_LO_LSB = 0;

endpackage

// File: rtl/linear_weight_loader_if.sv
// Byte-stream input, control/status and SRAM write port of the weight loader.
// slave = loader side, master = the controller / stream source side.
interface linear_weight_loader_if
    import linear_weight_pkg::*;
#(
    parameter int ADDR_W = LW_ADDR_W
);
    logic              start;
    logic              in_valid;
    logic              in_ready;
    logic [7:0]        in_data;
    logic              in_last;
    logic [ADDR_W-1:0] sram_adr;
    logic [15:0]       sram_d;
    logic              sram_we;
    logic              sram_me;
    logic              busy;
    logic              done;
    logic              err;
    logic [ADDR_W:0]   words_written;

    modport slave (
        input  start, in_valid, in_data, in_last,
        output in_ready, sram_adr, sram_d, sram_we, sram_me,
               busy, done, err, words_written
    );

    modport master (
        output start, in_valid, in_data, in_last,
        input  in_ready, sram_adr, sram_d, sram_we, sram_me,
               busy, done, err, words_written
    );

endinterface

// File: rtl/linear_weight_loader.sv
// Packs a stream of signed 8-bit weights into 16-bit SRAM words (first byte high)
// and writes them from address 0, flagging odd length or overrun in err.
module linear_weight_loader
    import linear_weight_pkg::*;
#(
    parameter int NUM_WORDS = LW_NUM_WORDS,
    parameter int ADDR_W    = LW_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst_b,
    linear_weight_loader_if.slave bus
);

    localparam logic [ADDR_W:0] LP_LAST_IDX = (ADDR_W+1)'(NUM_WORDS - 1);

    lw_state_t         r_state;
    logic              r_in_ready;
    logic              r_we;
    logic              r_me;
    logic              r_busy;
    logic              r_done;
    logic              r_err;
    logic              r_last_seen;
    logic [ADDR_W-1:0] r_adr;
    logic [15:0]       r_d;
    logic [ADDR_W:0]   r_words;

    logic w_accept;
    logic w_final_word;

    assign w_accept     = bus.in_valid && r_in_ready;
    assign w_final_word = (r_words == LP_LAST_IDX);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state     <= ST_IDLE;
            r_in_ready  <= 1'b0;
            r_we        <= 1'b0;
            r_me        <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_last_seen <= 1'b0;
            r_adr       <= '0;
            r_d         <= '0;
            r_words     <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        r_state     <= ST_LOAD_HI;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b1;
                        r_done      <= 1'b0;
                        r_err       <= 1'b0;
                        r_last_seen <= 1'b0;
                        r_adr       <= '0;
                        r_words     <= '0;
                    end
                end

                ST_LOAD_HI: begin
                    if (w_accept) begin
                        r_d[LANE_HI_MSB:LANE_HI_LSB] <= bus.in_data;
                        if (bus.in_last) begin
                            // odd-length stream: pad the missing weight1 and commit now
                            r_d[LANE_LO_MSB:LANE_LO_LSB] <= 8'h00;
                            r_err       <= 1'b1;
                            r_last_seen <= 1'b1;
                            r_state     <= ST_WRITE;
                            r_in_ready  <= 1'b0;
                            r_we        <= 1'b1;
                            r_me        <= 1'b1;
                        end else begin
                            r_state <= ST_LOAD_LO;
                        end
                    end
                end

                ST_LOAD_LO: begin
                    if (w_accept) begin
                        r_d[LANE_LO_MSB:LANE_LO_LSB] <= bus.in_data;
                        r_last_seen <= bus.in_last;
                        if (bus.in_last && !w_final_word) begin
                            r_err <= 1'b1;
                        end
                        r_state    <= ST_WRITE;
                        r_in_ready <= 1'b0;
                        r_we       <= 1'b1;
                        r_me       <= 1'b1;
                    end
                end

                ST_WRITE: begin
                    r_we    <= 1'b0;
                    r_me    <= 1'b0;
                    r_adr   <= r_adr + ADDR_W'(1);
                    r_words <= r_words + (ADDR_W+1)'(1);
                    if (r_last_seen || w_final_word) begin
                        // SRAM full while the stream still had bytes to give
                        if (!r_last_seen) begin
                            r_err <= 1'b1;
                        end
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_state    <= ST_LOAD_HI;
                        r_in_ready <= 1'b1;
                    end
                end

                default: begin
                    r_state    <= ST_IDLE;
                    r_in_ready <= 1'b0;
                    r_we       <= 1'b0;
                    r_me       <= 1'b0;
                    r_busy     <= 1'b0;
                    r_done     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready      = r_in_ready;
    assign bus.sram_adr      = r_adr;
    assign bus.sram_d        = r_d;
    assign bus.sram_we       = r_we;
    assign bus.sram_me       = r_me;
    assign bus.busy          = r_busy;
    assign bus.done          = r_done;
    assign bus.err           = r_err;
    assign bus.words_written = r_words;

endmodule

// File: tb/tb_linear_weight_loader.sv
// Scoreboard bench: expected SRAM writes are queued as stimulus is planned and
// checked against every write strobe; a 4-word instance covers overrun.
module tb_linear_weight_loader;
    import linear_weight_pkg::*;

    logic       clk = 1'b0;
    logic       rst_b = 1'b0;
    logic       start64 = 1'b0;
    logic       start4 = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_last = 1'b0;
    bit         sel = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] q64[$];
    logic [31:0] q4[$];

    always #5 clk = ~clk;

    linear_weight_loader_if #(.ADDR_W(9)) if64 ();
    linear_weight_loader_if #(.ADDR_W(9)) if4 ();

    assign if64.start    = start64;
    assign if64.in_valid = in_valid;
    assign if64.in_data  = in_data;
    assign if64.in_last  = in_last;
    assign if4.start     = start4;
    assign if4.in_valid  = in_valid;
    assign if4.in_data   = in_data;
    assign if4.in_last   = in_last;

    linear_weight_loader #(.NUM_WORDS(64), .ADDR_W(9)) u_dut64 (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (if64.slave)
    );

    linear_weight_loader #(.NUM_WORDS(4), .ADDR_W(9)) u_dut4 (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (if4.slave)
    );

    logic w_ready;
    logic w_done;
    assign w_ready = sel ? if4.in_ready : if64.in_ready;
    assign w_done  = sel ? if4.done : if64.done;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_word(input int adr, input logic [7:0] hi, input logic [7:0] lo);
        return (32'(adr) << 16) | {16'h0000, hi, lo};
    endfunction

    always @(negedge clk) begin
        if (rst_b && if64.sram_we) begin
            logic [31:0] got;
            got = 32'({if64.sram_adr, if64.sram_d});
            $display("wr64 adr=%0d d=0x%04h", if64.sram_adr, if64.sram_d);
            check_eq("wr64_ready_low", 32'(if64.in_ready), 32'd0);
            check_eq("wr64_me", 32'(if64.sram_me), 32'd1);
            check_eq("wr64_expected", 32'(q64.size() > 0), 32'd1);
            if (q64.size() > 0) check_eq("wr64_data", got, q64.pop_front());
        end
    end

    always @(negedge clk) begin
        if (rst_b && if4.sram_we) begin
            logic [31:0] got;
            got = 32'({if4.sram_adr, if4.sram_d});
            $display("wr4 adr=%0d d=0x%04h", if4.sram_adr, if4.sram_d);
            check_eq("wr4_ready_low", 32'(if4.in_ready), 32'd0);
            check_eq("wr4_adr_range", 32'(if4.sram_adr < 9'd4), 32'd1);
            check_eq("wr4_expected", 32'(q4.size() > 0), 32'd1);
            if (q4.size() > 0) check_eq("wr4_data", got, q4.pop_front());
        end
    end

    task automatic pulse_start(input bit which);
        if (which) start4 = 1'b1; else start64 = 1'b1;
        @(posedge clk); #1;
        start4  = 1'b0;
        start64 = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic l, input bit gap,
                             input int budget, output bit acc);
        int n;
        n = 0;
        acc = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!w_ready && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        if (w_ready) begin
            @(posedge clk); #1;
            acc = 1'b1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (gap) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!w_done && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("done_seen", 32'(w_done), 32'd1);
    endtask

    initial begin
        bit acc;
        int n_acc;
        logic [7:0] odd_bytes[5];
        odd_bytes = '{8'h81, 8'h02, 8'hFF, 8'h10, 8'h7F};

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_ready", 32'(if64.in_ready), 32'd0);
        check_eq("rst_we_me", 32'({if64.sram_we, if64.sram_me}), 32'd0);
        check_eq("rst_status", 32'({if64.busy, if64.done, if64.err}), 32'd0);
        check_eq("rst_adr_d", 32'({if64.sram_adr, if64.sram_d}), 32'd0);
        check_eq("rst_words", 32'(if64.words_written), 32'd0);
        check_eq("rst_state", 32'(u_dut64.r_state), 32'(ST_IDLE));
        rst_b = 1'b1;
        @(posedge clk); #1;

        // full load of 64 words, continuous stream
        sel = 1'b0;
        for (int k = 0; k < 64; k++) q64.push_back(exp_word(k, 8'(2*k), 8'(2*k+1)));
        pulse_start(1'b0);
        check_eq("full_busy", 32'(if64.busy), 32'd1);
        for (int i = 0; i < 128; i++) begin
            send_byte(8'(i), (i == 127), 1'b0, 200, acc);
            check_eq("full_accept", 32'(acc), 32'd1);
        end
        wait_done();
        check_eq("full_err", 32'(if64.err), 32'd0);
        check_eq("full_words", 32'(if64.words_written), 32'd64);
        check_eq("full_busy_off", 32'(if64.busy), 32'd0);
        check_eq("full_q_empty", 32'(q64.size()), 32'd0);
        $display("load full: words=%0d err=%0d", if64.words_written, if64.err);

        // odd-length stream ending in the high lane
        q64.push_back(exp_word(0, 8'h81, 8'h02));
        q64.push_back(exp_word(1, 8'hFF, 8'h10));
        q64.push_back(exp_word(2, 8'h7F, 8'h00));
        pulse_start(1'b0);
        check_eq("odd_err_cleared", 32'(if64.err), 32'd0);
        for (int i = 0; i < 5; i++) begin
            send_byte(odd_bytes[i], (i == 4), 1'b0, 200, acc);
            check_eq("odd_accept", 32'(acc), 32'd1);
        end
        wait_done();
        check_eq("odd_err", 32'(if64.err), 32'd1);
        check_eq("odd_words", 32'(if64.words_written), 32'd3);
        check_eq("odd_q_empty", 32'(q64.size()), 32'd0);
        $display("load odd: words=%0d err=%0d", if64.words_written, if64.err);

        // backpressure with a start pulse injected while in LOAD_LO
        for (int k = 0; k < 64; k++) q64.push_back(exp_word(k, 8'(2*k), 8'(2*k+1)));
        pulse_start(1'b0);
        for (int i = 0; i < 128; i++) begin
            send_byte(8'(i), (i == 127), 1'b0, 200, acc);
            check_eq("bp_accept", 32'(acc), 32'd1);
            if (i == 10) begin
                check_eq("bp_in_lo", 32'(u_dut64.r_state), 32'(ST_LOAD_LO));
                start64 = 1'b1;
            end
            @(posedge clk); #1;
            start64 = 1'b0;
        end
        wait_done();
        check_eq("bp_err", 32'(if64.err), 32'd0);
        check_eq("bp_words", 32'(if64.words_written), 32'd64);
        check_eq("bp_q_empty", 32'(q64.size()), 32'd0);
        $display("load backpressure: words=%0d err=%0d", if64.words_written, if64.err);

        // overrun on the 4-word instance
        sel = 1'b1;
        for (int k = 0; k < 4; k++) q4.push_back(exp_word(k, 8'(8'h20 + 2*k), 8'(8'h21 + 2*k)));
        pulse_start(1'b1);
        n_acc = 0;
        for (int i = 0; i < 10; i++) begin
            send_byte(8'(8'h20 + i), 1'b0, 1'b0, 20, acc);
            if (acc) n_acc++;
        end
        wait_done();
        check_eq("ovr_accepted", 32'(n_acc), 32'd8);
        check_eq("ovr_ready", 32'(if4.in_ready), 32'd0);
        check_eq("ovr_err", 32'(if4.err), 32'd1);
        check_eq("ovr_words", 32'(if4.words_written), 32'd4);
        check_eq("ovr_q_empty", 32'(q4.size()), 32'd0);
        $display("load overrun: accepted=%0d words=%0d err=%0d", n_acc, if4.words_written, if4.err);

        // reset mid-load after three words, then reload from address 0
        sel = 1'b0;
        for (int k = 0; k < 3; k++) q64.push_back(exp_word(k, 8'(8'h40 + 2*k), 8'(8'h41 + 2*k)));
        pulse_start(1'b0);
        for (int i = 0; i < 7; i++) begin
            send_byte(8'(8'h40 + i), 1'b0, 1'b0, 200, acc);
            check_eq("mid_accept", 32'(acc), 32'd1);
        end
        check_eq("mid_q_empty", 32'(q64.size()), 32'd0);
        @(negedge clk);
        rst_b = 1'b0;
        #1;
        check_eq("mid_rst_state", 32'(u_dut64.r_state), 32'(ST_IDLE));
        check_eq("mid_rst_outs", 32'({if64.in_ready, if64.sram_we, if64.busy, if64.done}), 32'd0);
        check_eq("mid_rst_words", 32'(if64.words_written), 32'd0);
        @(posedge clk); #1;
        check_eq("mid_rst_we_next", 32'(if64.sram_we), 32'd0);
        check_eq("mid_rst_state_next", 32'(u_dut64.r_state), 32'(ST_IDLE));
        rst_b = 1'b1;
        @(posedge clk); #1;
        q64.push_back(exp_word(0, 8'hA0, 8'hA1));
        q64.push_back(exp_word(1, 8'hA2, 8'hA3));
        pulse_start(1'b0);
        for (int i = 0; i < 4; i++) begin
            send_byte(8'(8'hA0 + i), (i == 3), 1'b0, 200, acc);
            check_eq("reload_accept", 32'(acc), 32'd1);
        end
        wait_done();
        check_eq("reload_err", 32'(if64.err), 32'd1);
        check_eq("reload_words", 32'(if64.words_written), 32'd2);
        check_eq("reload_q_empty", 32'(q64.size()), 32'd0);
        $display("load after reset: words=%0d err=%0d", if64.words_written, if64.err);

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/linear_weight_loader.md
LINEAR_WEIGHT_LOADER -- requirements
Module: linear_weight_loader

Interface
REQ-001 Parameter NUM_WORDS, default 64, SHALL set the number of 16-bit words in the linear-weight SRAM (range 1..512).
REQ-002 Parameter ADDR_W, default 9, SHALL set the SRAM address width.
REQ-003 clk  input  1  SHALL be the single clock; all logic is rising-edge.
REQ-004 rst_b  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 start  input  1  SHALL be a one-cycle pulse that begins a load (honoured only in IDLE or DONE).
REQ-006 in_valid  input  1  SHALL qualify in_data and in_last.
REQ-007 in_ready  output  1  SHALL indicate that the loader accepts a byte this cycle.
REQ-008 in_data  input  8  SHALL carry one signed 8-bit weight.
REQ-009 in_last  input  1  SHALL mark the final weight of the stream.
REQ-010 sram_adr  output  ADDR_W  SHALL carry the SRAM write address.
REQ-011 sram_d  output  16  SHALL carry the SRAM write data.
REQ-012 sram_we, sram_me  output  1 each  SHALL carry the SRAM write and macro enables; both are high only in WRITE.
REQ-013 busy  output  1  SHALL be high from the cycle after an accepted start until DONE is entered.
REQ-014 done  output  1  SHALL be high while in DONE.
REQ-015 err  output  1  SHALL flag a length mismatch (REQ-024, REQ-025); valid while done=1.
REQ-016 words_written  output  ADDR_W+1  SHALL count the words committed in the current load.

Function
REQ-017 The FSM SHALL have states IDLE, LOAD_HI, LOAD_LO, WRITE and DONE.
REQ-018 IDLE/DONE + start -> LOAD_HI; the start cycle clears address, words_written and err.
REQ-019 in_ready SHALL be 1 only in LOAD_HI and LOAD_LO; a byte is accepted when in_valid and in_ready are both 1.
REQ-020 A byte accepted in LOAD_HI SHALL be latched into sram_d[15:8], i.e. the weight0 position -> LOAD_LO.
REQ-021 A byte accepted in LOAD_LO SHALL be latched into sram_d[7:0], i.e. the weight1 position -> WRITE.
REQ-022 WRITE SHALL last exactly one cycle with sram_we=sram_me=1 at sram_adr, and SHALL increment sram_adr and words_written at its end.
  - Latency from the second-byte acceptance to the write strobe is 1 cycle.
  - Peak throughput is 2 bytes per 3 cycles.
REQ-023 After WRITE: go to DONE if the last byte has been seen or words_written reaches NUM_WORDS; otherwise go to LOAD_HI.
REQ-024 in_last accepted in LOAD_HI SHALL zero-fill sram_d[7:0], go directly to WRITE, and set err.
REQ-025 Reaching NUM_WORDS without in_last on the final byte SHALL set err; the loader SHALL NOT accept further bytes.
REQ-026 in_last accepted in LOAD_LO with words_written+1 == NUM_WORDS SHALL complete with err=0.
REQ-027 in_last accepted in LOAD_LO before the final word SHALL complete with err=1.
  - Words that were not written keep their old SRAM content.
REQ-028 start SHALL be ignored in LOAD_HI, LOAD_LO and WRITE.
REQ-029 sram_adr SHALL never exceed NUM_WORDS-1 while sram_we=1.
REQ-030 Outside WRITE, sram_we and sram_me SHALL be 0; sram_d and sram_adr hold their last values.

Reset
REQ-031 rst_b low SHALL immediately force:
  - state to IDLE;
  - in_ready, sram_we, sram_me, busy, done and err to 0;
  - sram_adr, sram_d and words_written to 0.
REQ-032 Reset asserted mid-load SHALL abort with no further SRAM writes; a partially written SRAM is not restored.

Structure
REQ-033 The state enum, NUM_WORDS default, ADDR_W default and the byte-lane constants (HI = 15:8, LO = 7:0) SHALL live in shared package linear_weight_pkg, which the reader side also imports.
REQ-034 The block SHALL be a single module with no sub-module; the SRAM macro is instantiated outside it, with sram_* connected to ADR, D, WE and ME.

Verification
REQ-035 Full load, NUM_WORDS=64:
  - stimulus: start, then 128 bytes 0x00..0x7F with in_last on byte 128;
  - response: 64 writes, word k = {2k, 2k+1}, done=1, err=0, words_written=64.
REQ-036 Odd length:
  - stimulus: 5 bytes 0x81, 0x02, 0xFF, 0x10, 0x7F (last);
  - response: writes 0x8102@0, 0xFF10@1, 0x7F00@2; err=1; words_written=3.
REQ-037 Backpressure:
  - stimulus: in_valid toggling every cycle;
  - response: data identical to REQ-035; in_ready=0 in every WRITE cycle; no byte lost or duplicated.
REQ-038 Overrun:
  - stimulus: NUM_WORDS=4, 10 bytes with no in_last;
  - response: 4 writes to addresses 0..3, then in_ready=0 and err=1.
REQ-039 Reset mid-load:
  - stimulus: rst_b low after 3 words;
  - response: the next cycle shows sram_we=0 and state IDLE; a new start writes from address 0.
REQ-040 start while busy:
  - stimulus: start pulse in LOAD_LO;
  - response: ignored; address sequence continues unchanged.
